// File: rtl/pipe_stage_buf_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : pipe_stage_buf_pkg                                             |
// | Purpose : Shared definitions for the inter-stage pipeline buffer: state  |
// |           encoding of the occupancy FSM, standard CTRL field offsets and |
// |           a state-to-occupancy helper.                                   |
// | Ports   : none (package)                                                 |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package pipe_stage_buf_pkg;

  // State encoding equals the number of held entries, so occ is a direct read.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  // Standard CTRL field layout shared by every stage instance.
  localparam int CTRL_MEM_R_EN   = 0;
  localparam int CTRL_MEM_W_EN   = 1;
  localparam int CTRL_WB_EN      = 2;
  localparam int CTRL_EXE_CMD_LSB = 3;
  localparam int CTRL_EXE_CMD_W  = 4;
  localparam int CTRL_BR_EN      = 7;

  function automatic logic [1:0] occ_of(input state_t s);
    return 2'(s);
  endfunction

endpackage : pipe_stage_buf_pkg
`default_nettype wire

// File: rtl/pipe_stage_buf_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : pipe_stage_buf_if                                              |
// | Purpose : Valid/ready stage bus carrying a control field and a datapath  |
// |           field.                                                         |
// | Ports   : valid, ready, ctrl[CTRL_W], data[DATA_W]                       |
// |           master : drives valid/ctrl/data, receives ready                |
// |           slave  : receives valid/ctrl/data, drives ready                |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
interface pipe_stage_buf_if #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 128
) ();
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);
endinterface : pipe_stage_buf_if
`default_nettype wire

// File: rtl/pipe_stage_buf_slot.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : pipe_stage_buf_slot                                            |
// | Purpose : One buffer entry: CTRL+DATA register with load enable and a    |
// |           valid flag that is rewritten every cycle.                      |
// | Ports   : clk, rst (async, active-low), load, valid_d, ctrl_d, data_d,   |
// |           valid_q, ctrl_q, data_q                                        |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module pipe_stage_buf_slot #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 128
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              load,
  input  wire logic              valid_d,
  input  wire logic [CTRL_W-1:0] ctrl_d,
  input  wire logic [DATA_W-1:0] data_d,
  output logic                   valid_q,
  output logic      [CTRL_W-1:0] ctrl_q,
  output logic      [DATA_W-1:0] data_q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      if (load) begin
        ctrl_q <= ctrl_d;
        data_q <= data_d;
      end
    end
  end

endmodule : pipe_stage_buf_slot
`default_nettype wire

// File: rtl/pipe_stage_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : pipe_stage_buf                                                 |
// | Purpose : Inter-stage pipeline register with valid/ready handshake,      |
// |           back-pressure, flush and an optional skid entry that makes     |
// |           the upstream ready a pure flop. Control bits are zeroed in     |
// |           bubbles.                                                       |
// | Ports   : clk, rst (async, active-low), flush                            |
// |           up  (slave)  : incoming entry (in_valid/in_ready/ctrl/data)    |
// |           dn  (master) : outgoing entry (out_valid/out_ready/ctrl/data)  |
// |           occ[1:0]     : entries held                                    |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 128,
  parameter int SKID   = 1
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         flush,
  pipe_stage_buf_if.slave   up,
  pipe_stage_buf_if.master  dn,
  output logic [1:0]        occ
);

  state_t              r_state;
  state_t              w_next;
  logic                w_push;
  logic                w_pop;
  logic                w_in_ready;
  logic                w_main_load;
  logic                w_main_valid;
  logic [CTRL_W-1:0]   w_main_ctrl;
  logic [DATA_W-1:0]   w_main_data;
  logic [CTRL_W-1:0]   w_main_ctrl_d;
  logic [DATA_W-1:0]   w_main_data_d;
  logic                w_skid_valid;
  logic [CTRL_W-1:0]   w_skid_ctrl;
  logic [DATA_W-1:0]   w_skid_data;

  assign w_push = up.valid && w_in_ready;
  assign w_pop  = w_main_valid && dn.ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_EMPTY;
    else      r_state <= w_next;
  end

  // Flush wins over everything: no load happens, so a flushed push can never
  // surface at the output.
  always_comb begin
    w_next      = r_state;
    w_main_load = 1'b0;
    if (flush) begin
      w_next = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            w_next      = ST_ONE;
            w_main_load = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_push && w_pop) begin
            w_main_load = 1'b1;
          end else if (w_push) begin
            w_next = ST_TWO;
          end else if (w_pop) begin
            w_next = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_pop) begin
            w_next      = ST_ONE;
            w_main_load = 1'b1;
          end
        end
        default: w_next = ST_EMPTY;
      endcase
    end
  end

  // Main reloads from skid whenever skid holds the older pending entry.
  assign w_main_ctrl_d = w_skid_valid ? w_skid_ctrl : up.ctrl;
  assign w_main_data_d = w_skid_valid ? w_skid_data : up.data;

  pipe_stage_buf_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) main (
    .clk     (clk),
    .rst     (rst),
    .load    (w_main_load),
    .valid_d (w_next != ST_EMPTY),
    .ctrl_d  (w_main_ctrl_d),
    .data_d  (w_main_data_d),
    .valid_q (w_main_valid),
    .ctrl_q  (w_main_ctrl),
    .data_q  (w_main_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic skid_load;
      logic r_in_ready;

      // Only ONE->TWO captures into skid (push while downstream stalls).
      assign skid_load = (r_state == ST_ONE) && (w_next == ST_TWO);

      pipe_stage_buf_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) skid (
        .clk     (clk),
        .rst     (rst),
        .load    (skid_load),
        .valid_d (w_next == ST_TWO),
        .ctrl_d  (up.ctrl),
        .data_d  (up.data),
        .valid_q (w_skid_valid),
        .ctrl_q  (w_skid_ctrl),
        .data_q  (w_skid_data)
      );

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_in_ready <= 1'b1;
        else      r_in_ready <= (w_next != ST_TWO);
      end

      assign w_in_ready = r_in_ready;
    end else begin : g_no_skid
      assign w_skid_valid = 1'b0;
      assign w_skid_ctrl  = '0;
      assign w_skid_data  = '0;
      // Single entry: ready combinationally follows out_ready when full.
      assign w_in_ready   = !w_main_valid || dn.ready;
    end
  endgenerate

  assign up.ready = w_in_ready;
  assign dn.valid = w_main_valid;
  assign dn.ctrl  = w_main_ctrl & {CTRL_W{w_main_valid}};
  assign dn.data  = w_main_data;
  assign occ      = occ_of(r_state);

endmodule : pipe_stage_buf
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_pipe_stage_buf                                              |
// | Purpose : Directed self-checking bench for pipe_stage_buf, covering the  |
// |           skid build (SKID=1) and the single-entry build (SKID=0).       |
// | Ports   : none                                                           |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_pipe_stage_buf;

  logic       clk;
  logic       rst;
  logic       flush_a;
  logic       flush_b;
  logic [1:0] occ_a;
  logic [1:0] occ_b;
  int         checks;
  int         failures;

  pipe_stage_buf_if #(.CTRL_W(8), .DATA_W(128)) ua ();
  pipe_stage_buf_if #(.CTRL_W(8), .DATA_W(128)) da ();
  pipe_stage_buf_if #(.CTRL_W(8), .DATA_W(128)) ub ();
  pipe_stage_buf_if #(.CTRL_W(8), .DATA_W(128)) db ();

  pipe_stage_buf #(.CTRL_W(8), .DATA_W(128), .SKID(1)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush_a),
    .up    (ua.slave),
    .dn    (da.master),
    .occ   (occ_a)
  );

  pipe_stage_buf #(.CTRL_W(8), .DATA_W(128), .SKID(0)) dut0 (
    .clk   (clk),
    .rst   (rst),
    .flush (flush_b),
    .up    (ub.slave),
    .dn    (db.master),
    .occ   (occ_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    flush_a  = 1'b0;
    flush_b  = 1'b0;
    ua.valid = 1'b1;
    ua.ctrl  = 8'hA5;
    ua.data  = 128'h99;
    da.ready = 1'b0;
    ub.valid = 1'b0;
    ub.ctrl  = 8'h00;
    ub.data  = 128'h0;
    db.ready = 1'b0;

    // 1 reset held with an entry offered upstream
    repeat (3) tick();
    chk("rst_out_valid", 128'(da.valid), 128'h0);
    chk("rst_out_ctrl",  128'(da.ctrl),  128'h0);
    chk("rst_out_data",  da.data,        128'h0);
    chk("rst_occ",       128'(occ_a),    128'h0);
    chk("rst_b_valid",   128'(db.valid), 128'h0);
    rst      = 1'b1;
    ua.valid = 1'b0;
    tick();
    chk("rst_in_ready",  128'(ua.ready), 128'h1);
    chk("rst_occ_after", 128'(occ_a),    128'h0);

    // 2 streaming, one entry per cycle, one cycle latency
    da.ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      ua.valid = 1'b1;
      ua.ctrl  = 8'(i);
      ua.data  = 128'(i);
      tick();
      chk("stream_valid", 128'(da.valid), 128'h1);
      chk("stream_data",  da.data,        128'(i));
      chk("stream_ctrl",  128'(da.ctrl),  128'(i));
      chk("stream_ready", 128'(ua.ready), 128'h1);
    end
    ua.valid = 1'b0;
    tick();
    chk("stream_drain_valid", 128'(da.valid), 128'h0);
    chk("stream_drain_occ",   128'(occ_a),    128'h0);

    // 3 stall with skid: A, B accepted, C held upstream
    da.ready = 1'b0;
    ua.valid = 1'b1;
    ua.ctrl  = 8'h11;
    ua.data  = 128'hA1;
    tick();
    chk("stall_occ1",   128'(occ_a),    128'h1);
    chk("stall_rdy1",   128'(ua.ready), 128'h1);
    ua.ctrl  = 8'h22;
    ua.data  = 128'hB2;
    tick();
    chk("stall_occ2",   128'(occ_a),    128'h2);
    chk("stall_rdy2",   128'(ua.ready), 128'h0);
    chk("stall_data_a", da.data,        128'hA1);
    ua.ctrl  = 8'h33;
    ua.data  = 128'hC3;
    tick();
    chk("stall_hold_occ",  128'(occ_a),    128'h2);
    chk("stall_hold_rdy",  128'(ua.ready), 128'h0);
    chk("stall_hold_data", da.data,        128'hA1);
    chk("stall_hold_ctrl", 128'(da.ctrl),  128'h11);
    da.ready = 1'b1;
    tick();
    chk("drain_data_b", da.data,        128'hB2);
    chk("drain_ctrl_b", 128'(da.ctrl),  128'h22);
    chk("drain_occ_b",  128'(occ_a),    128'h1);
    chk("drain_rdy_b",  128'(ua.ready), 128'h1);
    tick();
    chk("drain_data_c", da.data,        128'hC3);
    chk("drain_occ_c",  128'(occ_a),    128'h1);
    ua.valid = 1'b0;
    tick();
    chk("drain_empty",  128'(da.valid), 128'h0);
    chk("drain_occ0",   128'(occ_a),    128'h0);

    // 4a flush with two entries held and 0xDEAD offered
    da.ready = 1'b0;
    ua.valid = 1'b1;
    ua.ctrl  = 8'h44;
    ua.data  = 128'h111;
    tick();
    ua.data  = 128'h222;
    tick();
    chk("flush_pre_occ", 128'(occ_a), 128'h2);
    flush_a  = 1'b1;
    ua.ctrl  = 8'hFF;
    ua.data  = 128'hDEAD;
    tick();
    chk("flush2_occ",   128'(occ_a),    128'h0);
    chk("flush2_valid", 128'(da.valid), 128'h0);
    chk("flush2_ctrl",  128'(da.ctrl),  128'h0);
    flush_a  = 1'b0;
    ua.valid = 1'b0;
    tick();
    chk("flush2_after_valid", 128'(da.valid), 128'h0);
    chk("flush2_after_rdy",   128'(ua.ready), 128'h1);

    // 4b flush with one entry held while upstream can push
    ua.valid = 1'b1;
    ua.ctrl  = 8'h55;
    ua.data  = 128'h333;
    tick();
    chk("flush1_pre_rdy", 128'(ua.ready), 128'h1);
    flush_a  = 1'b1;
    ua.ctrl  = 8'hFF;
    ua.data  = 128'hDEAD;
    tick();
    chk("flush1_occ",   128'(occ_a),    128'h0);
    chk("flush1_valid", 128'(da.valid), 128'h0);
    flush_a  = 1'b0;
    ua.valid = 1'b0;
    tick();
    chk("flush1_after_occ",  128'(occ_a),                128'h0);
    chk("flush1_no_dead",    128'(da.data == 128'hDEAD), 128'h0);

    // 5 bubble control: ctrl offered without valid never reaches out_ctrl
    da.ready = 1'b1;
    ua.valid = 1'b0;
    ua.ctrl  = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bubble_ctrl",  128'(da.ctrl),  128'h0);
      chk("bubble_valid", 128'(da.valid), 128'h0);
    end

    // 6 single-entry build: combinational ready
    db.ready = 1'b0;
    ub.valid = 1'b1;
    ub.ctrl  = 8'h05;
    ub.data  = 128'h5;
    #1;
    chk("b_rdy_empty", 128'(ub.ready), 128'h1);
    tick();
    chk("b_occ1",      128'(occ_b),    128'h1);
    chk("b_rdy_stall", 128'(ub.ready), 128'h0);
    chk("b_data5",     db.data,        128'h5);
    db.ready = 1'b1;
    ub.ctrl  = 8'h06;
    ub.data  = 128'h6;
    #1;
    chk("b_rdy_comb",  128'(ub.ready), 128'h1);
    tick();
    chk("b_occ_stay",  128'(occ_b),    128'h1);
    chk("b_data6",     db.data,        128'h6);
    chk("b_ctrl6",     128'(db.ctrl),  128'h06);
    ub.valid = 1'b0;
    tick();
    chk("b_occ0",      128'(occ_b),    128'h0);
    chk("b_ctrl0",     128'(db.ctrl),  128'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pipe_stage_buf
`default_nettype wire
